// File: rtl/hazard_stall_if.sv
// hazard_stall_if: pipeline <-> hazard unit signal bundle; Stall_Cnt/Flush_Cnt exist only with HAZARD_PERF_CNT_EN.
interface hazard_stall_if #(parameter int CNT_W = 32);
    logic [4:0] RS1_D, RS2_D, Rd_E;
    logic ResultSrc_E, RegWrite_E, PCSrc_E, Mem_Req_M, Mem_Ready_M;
    logic Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Bubble_W, Mem_Err;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] Stall_Cnt, Flush_Cnt;
    modport master (
        output RS1_D, RS2_D, Rd_E, ResultSrc_E, RegWrite_E, PCSrc_E, Mem_Req_M, Mem_Ready_M,
        input  Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Bubble_W, Mem_Err, Stall_Cnt, Flush_Cnt
    );
    modport slave (
        input  RS1_D, RS2_D, Rd_E, ResultSrc_E, RegWrite_E, PCSrc_E, Mem_Req_M, Mem_Ready_M,
        output Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Bubble_W, Mem_Err, Stall_Cnt, Flush_Cnt
    );
`else
    modport master (
        output RS1_D, RS2_D, Rd_E, ResultSrc_E, RegWrite_E, PCSrc_E, Mem_Req_M, Mem_Ready_M,
        input  Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Bubble_W, Mem_Err
    );
    modport slave (
        input  RS1_D, RS2_D, Rd_E, ResultSrc_E, RegWrite_E, PCSrc_E, Mem_Req_M, Mem_Ready_M,
        output Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Bubble_W, Mem_Err
    );
`endif
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use / branch-squash / memory-wait stall and flush control with timeout FSM.
// Optional performance counters enabled by HAZARD_PERF_CNT_EN.
module hazard_stall_unit #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input logic clk,
    input logic rst,
    hazard_stall_if.slave hz
);
    typedef enum logic {RUN, WAIT} state_t;
    state_t state, state_n;
    logic [7:0] wait_cnt;
    logic lu, mw, tmo, ms, mem_err;
    logic [3:0] stall;
    logic flush_d, flush_e, bubble_w;

    assign lu  = hz.ResultSrc_E & hz.RegWrite_E & (hz.Rd_E != 5'd0) &
                 ((hz.Rd_E == hz.RS1_D) | (hz.Rd_E == hz.RS2_D));
    assign mw  = hz.Mem_Req_M & ~hz.Mem_Ready_M;
    assign tmo = (state == WAIT) & (wait_cnt == 8'(MAX_WAIT - 1)) & mw;
    assign ms  = mw & ~tmo;

    always_comb begin
        state_n = rst ? RUN : (ms ? WAIT : RUN);
    end

    // wait_cnt counts cycles already spent waiting, so the MAX_WAIT-th wait cycle times out
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= (state_n == WAIT) ? wait_cnt + 8'd1 : 8'd0;
            mem_err  <= mem_err | tmo;
        end
    end

    always_comb begin
        stall    = 4'b0000;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        bubble_w = 1'b0;
        if (rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (ms) begin
            stall    = 4'b1111;
            bubble_w = 1'b1;
        end else if (tmo) begin
            bubble_w = 1'b1;
        end else if (hz.PCSrc_E) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lu) begin
            stall   = 4'b1100;
            flush_e = 1'b1;
        end
    end

    assign hz.Stall_F  = stall[3];
    assign hz.Stall_D  = stall[2];
    assign hz.Stall_E  = stall[1];
    assign hz.Stall_M  = stall[0];
    assign hz.Flush_D  = flush_d;
    assign hz.Flush_E  = flush_e;
    assign hz.Bubble_W = bubble_w;
    assign hz.Mem_Err  = mem_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (|stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
            if ((flush_d | flush_e) && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
        end
    end
    assign hz.Stall_Cnt = stall_cnt;
    assign hz.Flush_Cnt = flush_cnt;
`endif
endmodule
